// File: rtl/synth_pkg.sv
// Shared types and constants for the envelope follower.
package synth_pkg;

  localparam int SAMPLE_W = 16;
  localparam logic [SAMPLE_W-1:0] ENV_MAX = 16'h7FFF;

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    HOLD
  } gate_state_t;

endpackage

// File: rtl/env_abs_sat.sv
// Saturating absolute value of a signed sample: -32768 folds to 0x7FFF so the
// result always fits the positive envelope range.
module env_abs_sat
  import synth_pkg::*;
(
  input  logic [SAMPLE_W-1:0] i_sample,
  output logic [SAMPLE_W-1:0] o_mag
);

  logic w_neg;
  logic w_most_neg;

  assign w_neg      = i_sample[SAMPLE_W-1];
  assign w_most_neg = (i_sample == {1'b1, {(SAMPLE_W-1){1'b0}}});

  // Rectify, clamping the one negative value that has no positive twin.
  always_comb begin
    if (w_most_neg)  o_mag = ENV_MAX;
    else if (w_neg)  o_mag = ~i_sample + SAMPLE_W'(1);
    else             o_mag = i_sample;
  end

endmodule

// File: rtl/env_follower.sv
// Envelope follower: rectifies a signed sample stream, smooths it with an
// asymmetric attack/release shift filter and derives a hysteretic gate with
// hold. Optional peak-hold output enabled by defining ENV_FOLLOWER_PEAK_EN.
module env_follower
  import synth_pkg::*;
#(
  parameter int SHIFT_W = 4,
  parameter int HOLD_W  = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [SHIFT_W-1:0]  attack_shift,
  input  logic [SHIFT_W-1:0]  release_shift,
  input  logic [SAMPLE_W-1:0] on_th,
  input  logic [SAMPLE_W-1:0] off_th,
  input  logic [HOLD_W-1:0]   hold_samples,
  output logic [SAMPLE_W-1:0] env_out,
  output logic                env_valid,
  output logic                gate_out,
  output logic                gate_rise,
  output logic                gate_fall,
  output logic [SAMPLE_W-1:0] peak_out,
  input  logic                peak_clr
);

  // ---------------- stage 1: rectification ----------------
  logic [SAMPLE_W-1:0] w_mag;
  logic [SAMPLE_W-1:0] r_mag;
  logic                r_s1_valid;

  env_abs_sat u_abs (
    .i_sample (sample_in),
    .o_mag    (w_mag)
  );

  // Register the rectified magnitude alongside its valid flag.
  always_ff @(posedge CLK) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (RESET) begin
      r_s1_valid <= 1'b0;
      r_mag      <= '0;
    end else begin
      r_s1_valid <= sample_valid;
      if (sample_valid) r_mag <= w_mag;
    end
  end

  // ---------------- stage 2: smoothing ----------------
  logic [SAMPLE_W-1:0] r_env;
  logic                r_env_valid;
  logic                w_up;
  logic [SAMPLE_W-1:0] w_diff;
  logic [SAMPLE_W-1:0] w_shifted;
  logic [SAMPLE_W-1:0] w_step;
  logic [SAMPLE_W-1:0] w_env_next;

  // Step toward the magnitude; a minimum step of 1 guarantees convergence.
  always_comb begin
    w_up       = (r_mag > r_env);
    w_diff     = w_up ? (r_mag - r_env) : (r_env - r_mag);
    w_shifted  = w_diff >> (w_up ? attack_shift : release_shift);
    w_step     = ((w_shifted == '0) && (w_diff != '0)) ? SAMPLE_W'(1) : w_shifted;
    w_env_next = w_up ? (r_env + w_step) : (r_env - w_step);
  end

  // Envelope register and its one-cycle update strobe.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_env       <= '0;
      r_env_valid <= 1'b0;
    end else begin
      r_env_valid <= r_s1_valid;
      if (r_s1_valid) r_env <= w_env_next;
    end
  end

  assign env_out   = r_env;
  assign env_valid = r_env_valid;

  // ---------------- gate FSM ----------------
  gate_state_t         r_state;
  gate_state_t         w_state_next;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [HOLD_W-1:0]   w_hold_next;
  logic [SAMPLE_W-1:0] w_eoff;
  logic                w_rise;
  logic                w_fall;
  logic                r_gate;
  logic                r_rise;
  logic                r_fall;

  // Next-state logic, advanced only on envelope update cycles.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    w_hold_next  = r_hold_cnt;
    w_rise       = 1'b0;
    w_fall       = 1'b0;
    w_eoff       = (off_th < on_th) ? off_th : on_th;
    if (r_s1_valid) begin
      unique case (r_state)
        IDLE: begin
          if (w_env_next >= on_th) begin
            w_state_next = OPEN;
            w_rise       = 1'b1;
          end
        end
        OPEN: begin
          if (w_env_next < w_eoff) begin
            if (hold_samples == '0) begin
              w_state_next = IDLE;
              w_fall       = 1'b1;
            end else begin
              w_state_next = HOLD;
              w_hold_next  = hold_samples;
            end
          end
        end
        HOLD: begin
          if (w_env_next >= on_th) begin
            w_state_next = OPEN;
          end else if (r_hold_cnt <= HOLD_W'(1)) begin
            w_state_next = IDLE;
            w_hold_next  = '0;
            w_fall       = 1'b1;
          end else begin
            w_hold_next  = r_hold_cnt - HOLD_W'(1);
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Gate state, hold counter and registered gate outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_gate     <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_next;
      r_gate     <= (w_state_next != IDLE);
      r_rise     <= w_rise;
      r_fall     <= w_fall;
    end
  end

  assign gate_out  = r_gate;
  assign gate_rise = r_rise;
  assign gate_fall = r_fall;

  // ---------------- optional peak hold ----------------
`ifdef ENV_FOLLOWER_PEAK_EN
  logic [SAMPLE_W-1:0] r_peak;

  // Track the largest envelope seen; a clear restarts from the current update.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_peak <= '0;
    end else if (peak_clr) begin
      r_peak <= r_s1_valid ? w_env_next : '0;
    end else if (r_s1_valid && (w_env_next > r_peak)) begin
      r_peak <= w_env_next;
    end
  end

  assign peak_out = r_peak;
`else
  logic w_unused_peak_clr;
  assign w_unused_peak_clr = peak_clr;
  assign peak_out          = '0;
`endif

endmodule
